// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    localparam int SLICE_W = 4;

endpackage

// File: rtl/adder4.sv
// 4-bit ripple-carry slice; purely combinational, reused once per nibble by the sequencer.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[4];
    end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per cycle through a shared adder4, LSB first.
// Run/Done four-phase handshake; result, carry and overflow update only on the final slice.
module nibble_serial_addsub_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Busy,
    output logic             Done
);

    localparam int NSL = WIDTH / SLICE_W;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

    if ((WIDTH % SLICE_W) != 0 || WIDTH == 0) begin : g_width_chk
        $error("nibble_serial_addsub_ctrl: WIDTH must be a non-zero multiple of 4");
    end

    addsub_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;

    logic [SLICE_W-1:0] a_nib, b_nib, sum_nib;
    logic               cout_nib;

    // Nibble mux written with constant indices so the slice select stays a plain decoder.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NSL; i++) begin
            if (cnt_q == CW'(i)) begin
                a_nib = a_q[i*SLICE_W +: SLICE_W];
                b_nib = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    adder4 u_adder4 (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (c_q),
        .sum  (sum_nib),
        .cout (cout_nib)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cout_d  = cout_q;
        v_d     = v_q;

        case (state_q)
            IDLE: begin
                if (Run) begin
                    a_d     = A;
                    b_d     = B ^ {WIDTH{Sub}};
                    c_d     = Sub;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1] ^ Sub;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int i = 0; i < NSL; i++) begin
                    if (cnt_q == CW'(i)) begin
                        acc_d[i*SLICE_W +: SLICE_W] = sum_nib;
                    end
                end
                c_d = cout_nib;
                if (cnt_q == CW'(NSL - 1)) begin
                    s_d     = acc_d;
                    cout_d  = cout_nib;
                    v_d     = (a_msb_q == b_msb_q) && (acc_d[WIDTH-1] != a_msb_q);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            acc_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign V    = v_q;
    assign Busy = (state_q == ADD);
    assign Done = (state_q == DONE);

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Self-checking bench: directed corner cases, reset-in-flight, Run-held, and random ops vs an arithmetic model.
module tb_nibble_serial_addsub_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic         sub;
    logic [W-1:0] a_in, b_in;
    logic [W-1:0] s_out;
    logic         cout_out, v_out, busy_out, done_out;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] last_s = '0;

    nibble_serial_addsub_ctrl #(.WIDTH(W)) dut (
        .Clk   (clk),
        .Reset (rst),
        .Run   (run),
        .Sub   (sub),
        .A     (a_in),
        .B     (b_in),
        .S     (s_out),
        .Cout  (cout_out),
        .V     (v_out),
        .Busy  (busy_out),
        .Done  (done_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as numbers.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] res, output logic c, output logic v);
        logic [W:0] wide;
        int sa, sb, sr;
        sa = $signed(a);
        sb = $signed(b);
        if (s) begin
            wide = {1'b0, a} + {1'b0, ~b} + 17'd1;
            sr   = sa - sb;
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            sr   = sa + sb;
        end
        res = wide[W-1:0];
        c   = wide[W];
        v   = (sr > 32767) || (sr < -32768);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit hold_run, input bit scramble, input string tag);
        logic [W-1:0] er;
        logic         ec, ev;
        int           cyc;
        model(a, b, s, er, ec, ev);
        @(negedge clk);
        a_in = a; b_in = b; sub = s; run = 1'b1;
        @(negedge clk);
        check_val({tag, "_busy"}, busy_out, 1);
        check_val({tag, "_nopartial"}, s_out, last_s);
        if (!hold_run) run = 1'b0;
        cyc = 0;
        while (!done_out && cyc < 20) begin
            if (scramble) begin
                a_in = W'($urandom); b_in = W'($urandom); sub = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_lat"}, cyc, 4);
        check_val({tag, "_s"}, s_out, er);
        check_val({tag, "_cout"}, cout_out, ec);
        check_val({tag, "_v"}, v_out, ev);
        last_s = er;
        if (hold_run) begin
            repeat (3) @(negedge clk);
            check_val({tag, "_hold_done"}, done_out, 1);
            check_val({tag, "_hold_busy"}, busy_out, 0);
            check_val({tag, "_hold_s"}, s_out, er);
            run = 1'b0;
        end
        @(negedge clk);
        check_val({tag, "_idle"}, {busy_out, done_out}, 0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        check_val("rst_s", s_out, 0);
        check_val("rst_flags", {cout_out, v_out, busy_out, done_out}, 0);
        rst = 1'b0;

        run_op(16'h1234, 16'h4321, 1'b0, 0, 0, "t1");
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 0, "t2");
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 0, "t3a");
        run_op(16'h0005, 16'h0007, 1'b1, 0, 0, "t3b");
        run_op(16'h8000, 16'h0001, 1'b1, 0, 0, "t4");

        // Reset landing on the second ADD cycle discards the op.
        @(negedge clk);
        a_in = 16'hABCD; b_in = 16'h1111; sub = 1'b0; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("t5_busy", busy_out, 0);
        check_val("t5_done", done_out, 0);
        check_val("t5_s", s_out, 0);
        check_val("t5_cv", {cout_out, v_out}, 0);
        last_s = '0;
        run_op(16'h0F0F, 16'h00F1, 1'b0, 0, 0, "t5_fresh");

        run_op(16'h2468, 16'h1357, 1'b1, 1, 1, "t6");

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
